// File: rtl/fetch_stage.sv
// Instruction-fetch stage and F/D pipeline latch feeding instruction_decoder.
// Owns the PC, handles stall, redirect/flush, and the single post-reset boot bubble.
module fetch_stage #(
  parameter int          ADDR_W   = 12,
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] NOP      = 32'd0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_q,
  output logic [31:0]       fd_instruction,
  output logic [31:0]       fd_pc,
  output logic [31:0]       fd_pc_plus1,
  output logic              fd_valid,
  output logic [31:0]       fetch_count
);

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic        load_nop, take_redirect, advance;

  assign imem_addr = pc[ADDR_W-1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= BOOT;
    else          state <= state_nxt;
  end

  // BOOT ignores redirect so the first fetch always starts at RESET_PC.
  always_comb begin
    state_nxt     = state;
    load_nop      = 1'b0;
    take_redirect = 1'b0;
    advance       = 1'b0;
    case (state)
      BOOT: begin
        state_nxt = RUN;
        load_nop  = 1'b1;
      end
      RUN: begin
        if (redirect)    take_redirect = 1'b1;
        else if (!stall) advance       = 1'b1;
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc             <= RESET_PC;
      fd_instruction <= NOP;
      fd_pc          <= 32'd0;
      fd_pc_plus1    <= 32'd0;
      fd_valid       <= 1'b0;
      fetch_count    <= 32'd0;
    end else if (take_redirect) begin
      pc             <= redirect_pc;
      fd_instruction <= NOP;
      fd_pc          <= 32'd0;
      fd_pc_plus1    <= 32'd0;
      fd_valid       <= 1'b0;
    end else if (load_nop) begin
      fd_instruction <= NOP;
      fd_valid       <= 1'b0;
    end else if (advance) begin
      fd_instruction <= imem_q;
      fd_pc          <= pc;
      fd_pc_plus1    <= pc + 32'd1;
      fd_valid       <= 1'b1;
      pc             <= pc + 32'd1;
      fetch_count    <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed reset/boot sequences, a vector table, and a
// randomized run against a rule-level reference model of the fetch stage.
module tb_fetch_stage;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              stall;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_q;
  logic [31:0]       fd_instruction;
  logic [31:0]       fd_pc;
  logic [31:0]       fd_pc_plus1;
  logic              fd_valid;
  logic [31:0]       fetch_count;

  logic [31:0] imem [DEPTH];
  assign imem_q = imem[imem_addr];

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [31:0] m_pc, m_fdi, m_fdpc, m_fdp1, m_cnt;
  logic        m_valid;

  always #5 clock = ~clock;

  fetch_stage #(.ADDR_W(ADDR_W), .RESET_PC(32'd0), .NOP(32'd0)) dut (
    .clock(clock), .reset_n(reset_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_q(imem_q),
    .fd_instruction(fd_instruction), .fd_pc(fd_pc), .fd_pc_plus1(fd_pc_plus1),
    .fd_valid(fd_valid), .fetch_count(fetch_count)
  );

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic [31:0] exp_fd_pc;
    logic        exp_valid;
    logic [11:0] exp_addr;
    logic [31:0] exp_cnt;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // advance one clock; sample 1 time unit after the rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // model of one RUN-state edge, written from the priority rules
  task automatic model_step();
    if (redirect) begin
      m_pc = redirect_pc; m_fdi = 32'd0; m_valid = 1'b0; m_fdpc = 32'd0; m_fdp1 = 32'd0;
    end else if (!stall) begin
      m_fdi = imem[m_pc[ADDR_W-1:0]]; m_fdpc = m_pc; m_fdp1 = m_pc + 32'd1;
      m_valid = 1'b1; m_pc = m_pc + 32'd1; m_cnt = m_cnt + 32'd1;
    end
  endtask

  vec_t vecs [12];

  initial begin
    for (int i = 0; i < DEPTH; i++) imem[i] = $urandom;
    reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;

    // reset held for 3 cycles
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_valid", {31'd0, fd_valid}, 32'd0);
      check("rst_cnt", fetch_count, 32'd0);
      check("rst_addr", {20'd0, imem_addr}, 32'd0);
    end
    check("rst_instr", fd_instruction, 32'd0);
    check("rst_fdpc", fd_pc, 32'd0);
    check("rst_fdp1", fd_pc_plus1, 32'd0);
    @(negedge clock); reset_n = 1'b1;
    tick();
    check("boot_valid", {31'd0, fd_valid}, 32'd0);
    check("boot_addr", {20'd0, imem_addr}, 32'd0);
    tick();
    check("first_instr", fd_instruction, imem[0]);
    check("first_fdpc", fd_pc, 32'd0);
    check("first_fdp1", fd_pc_plus1, 32'd1);
    check("first_addr", {20'd0, imem_addr}, 32'd1);
    check("first_valid", {31'd0, fd_valid}, 32'd1);

    // table: straight-line, stall, redirect+stall, wrap, address aliasing
    vecs[0]  = '{1'b0, 1'b0, 32'd0,         32'd1,         1'b1, 12'h002, 32'd2};
    vecs[1]  = '{1'b0, 1'b0, 32'd0,         32'd2,         1'b1, 12'h003, 32'd3};
    vecs[2]  = '{1'b1, 1'b0, 32'd0,         32'd2,         1'b1, 12'h003, 32'd3};
    vecs[3]  = '{1'b1, 1'b0, 32'd0,         32'd2,         1'b1, 12'h003, 32'd3};
    vecs[4]  = '{1'b0, 1'b0, 32'd0,         32'd3,         1'b1, 12'h004, 32'd4};
    vecs[5]  = '{1'b0, 1'b0, 32'd0,         32'd4,         1'b1, 12'h005, 32'd5};
    vecs[6]  = '{1'b1, 1'b1, 32'h40,        32'd0,         1'b0, 12'h040, 32'd5};
    vecs[7]  = '{1'b0, 1'b0, 32'd0,         32'h40,        1'b1, 12'h041, 32'd6};
    vecs[8]  = '{1'b0, 1'b1, 32'hFFFFFFFF,  32'd0,         1'b0, 12'hFFF, 32'd6};
    vecs[9]  = '{1'b0, 1'b0, 32'd0,         32'hFFFFFFFF,  1'b1, 12'h000, 32'd7};
    vecs[10] = '{1'b0, 1'b1, 32'h00001234,  32'd0,         1'b0, 12'h234, 32'd7};
    vecs[11] = '{1'b0, 1'b0, 32'd0,         32'h00001234,  1'b1, 12'h235, 32'd8};
    for (int i = 0; i < 12; i++) begin
      stall = vecs[i].stall; redirect = vecs[i].redirect; redirect_pc = vecs[i].rpc;
      tick();
      check($sformatf("vec%0d_fdpc", i), fd_pc, vecs[i].exp_fd_pc);
      check($sformatf("vec%0d_valid", i), {31'd0, fd_valid}, {31'd0, vecs[i].exp_valid});
      check($sformatf("vec%0d_addr", i), {20'd0, imem_addr}, {20'd0, vecs[i].exp_addr});
      check($sformatf("vec%0d_cnt", i), fetch_count, vecs[i].exp_cnt);
      check($sformatf("vec%0d_instr", i), fd_instruction,
            vecs[i].exp_valid ? imem[vecs[i].exp_fd_pc[ADDR_W-1:0]] : 32'd0);
      check($sformatf("vec%0d_fdp1", i), fd_pc_plus1,
            vecs[i].exp_valid ? vecs[i].exp_fd_pc + 32'd1 : 32'd0);
    end
    stall = 1'b0; redirect = 1'b0;

    // async reset between edges while stalled; redirect during BOOT is ignored
    stall = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("async_valid", {31'd0, fd_valid}, 32'd0);
    check("async_fdpc", fd_pc, 32'd0);
    check("async_cnt", fetch_count, 32'd0);
    check("async_addr", {20'd0, imem_addr}, 32'd0);
    @(negedge clock); reset_n = 1'b1; stall = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h80;
    tick();
    check("reboot_valid", {31'd0, fd_valid}, 32'd0);
    check("reboot_addr", {20'd0, imem_addr}, 32'd0);
    redirect = 1'b0;
    tick();
    check("reboot_fdpc", fd_pc, 32'd0);
    check("reboot_instr", fd_instruction, imem[0]);
    check("reboot_cnt", fetch_count, 32'd1);

    // randomized run against the model
    m_pc = 32'd1; m_fdi = imem[0]; m_fdpc = 32'd0; m_fdp1 = 32'd1; m_valid = 1'b1; m_cnt = 32'd1;
    for (int c = 0; c < 400; c++) begin
      stall    = ($urandom_range(0, 9) < 3);
      redirect = ($urandom_range(0, 9) < 2);
      case ($urandom_range(0, 3))
        0:       redirect_pc = 32'hFFFFFFFF - $urandom_range(0, 2);
        1:       redirect_pc = $urandom_range(0, 16);
        default: redirect_pc = $urandom;
      endcase
      @(posedge clock);
      model_step();
      #1;
      check("rnd_instr", fd_instruction, m_fdi);
      check("rnd_fdpc", fd_pc, m_fdpc);
      check("rnd_fdp1", fd_pc_plus1, m_fdp1);
      check("rnd_valid", {31'd0, fd_valid}, {31'd0, m_valid});
      check("rnd_cnt", fetch_count, m_cnt);
      check("rnd_addr", {20'd0, imem_addr}, {20'd0, m_pc[ADDR_W-1:0]});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
